// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
// Read-mode encodings and the default almost-full threshold.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int afull_thr_default(input int addr);
    int depth;
    depth = 1 << addr;
    // Depth 2 would give 0, which is outside the legal threshold range.
    return (depth > 2) ? depth - 2 : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous read.
// Contents are never reset.
module fifo_mem #(
  parameter int N    = 16,
  parameter int ADDR = 4
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [ADDR-1:0] waddr_i,
  input  logic [N-1:0]    wdata_i,
  input  logic [ADDR-1:0] raddr_i,
  output logic [N-1:0]    rdata_o
);

  logic [N-1:0] mem_q [2**ADDR];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or FWFT read mode,
// occupancy flags, sticky error flags and synchronous flush.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int N          = 16,
  parameter int ADDR       = 4,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AFULL_THR  = afull_thr_default(ADDR),
  parameter int AEMPTY_THR = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          clr_err,
  input  logic          wr_en,
  input  logic [N-1:0]  wr_data,
  input  logic          rd_en,
  output logic [N-1:0]  rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [ADDR:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [ADDR:0] DEPTH = (ADDR+1)'(1 << ADDR);
  localparam logic [ADDR:0] AF_C  = (ADDR+1)'(AFULL_THR);
  localparam logic [ADDR:0] AE_C  = (ADDR+1)'(AEMPTY_THR);
  localparam logic [ADDR:0] ONE   = (ADDR+1)'(1);

  logic [ADDR:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_acc, rd_acc;
  logic [N-1:0]  mem_rdata;

  // Extra pointer bit distinguishes full from empty.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == DEPTH);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q & ~clr_err;
    unf_d    = unf_q & ~clr_err;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
      if (wr_en & full) ovf_d = 1'b1;
      if (rd_en & empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .N    (N),
    .ADDR (ADDR)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q[ADDR-1:0]),
    .rdata_o (mem_rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign rd_data  = empty ? '0 : mem_rdata;
    assign rd_valid = ~empty;
  end else begin : g_std
    logic [N-1:0] rd_data_q;
    logic         rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem_rdata;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: standard and FWFT instances share stimulus
// and are compared every cycle against a queue-based model.
module tb_sync_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        clr_err = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        rd_en = 1'b0;

  logic [15:0] rds, rdf;
  logic        rvs, rvf;
  logic        fus, fuf, ems, emf;
  logic        afs, aff, aes, aef;
  logic [3:0]  cns, cnf;
  logic        ovs, ovf, uns, unf;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  logic [15:0] q[$];
  bit          m_ovf, m_unf, m_sv;
  logic [15:0] m_sd;

  always #5 clk = ~clk;

  sync_fifo #(
    .N(16), .ADDR(3), .FWFT(0), .AFULL_THR(6), .AEMPTY_THR(1)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rds), .rd_valid(rvs), .full(fus), .empty(ems),
    .almost_full(afs), .almost_empty(aes), .count(cns),
    .overflow(ovs), .underflow(uns)
  );

  sync_fifo #(
    .N(16), .ADDR(3), .FWFT(1), .AFULL_THR(6), .AEMPTY_THR(1)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rdf), .rd_valid(rvf), .full(fuf), .empty(emf),
    .almost_full(aff), .almost_empty(aef), .count(cnf),
    .overflow(ovf), .underflow(unf)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    m_sv  = 0;
    m_sd  = '0;
  endtask

  task automatic model_step();
    int n;
    bit fl, em;
    n  = q.size();
    fl = (n == 8);
    em = (n == 0);
    if (clr_err) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (!flush && wr_en && fl) m_ovf = 1;
    if (!flush && rd_en && em) m_unf = 1;
    if (flush) begin
      q.delete();
      m_sv = 0;
    end else begin
      m_sv = rd_en && !em;
      if (m_sv) m_sd = q.pop_front();
      if (wr_en && !fl) q.push_back(wr_data);
    end
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    chk("count_s", 32'(cns), n);
    chk("count_f", 32'(cnf), n);
    chk("full_s", 32'(fus), 32'(n == 8));
    chk("full_f", 32'(fuf), 32'(n == 8));
    chk("empty_s", 32'(ems), 32'(n == 0));
    chk("empty_f", 32'(emf), 32'(n == 0));
    chk("afull_s", 32'(afs), 32'(n >= 6));
    chk("afull_f", 32'(aff), 32'(n >= 6));
    chk("aempty_s", 32'(aes), 32'(n <= 1));
    chk("aempty_f", 32'(aef), 32'(n <= 1));
    chk("ovf_s", 32'(ovs), 32'(m_ovf));
    chk("ovf_f", 32'(ovf), 32'(m_ovf));
    chk("unf_s", 32'(uns), 32'(m_unf));
    chk("unf_f", 32'(unf), 32'(m_unf));
    chk("rvalid_s", 32'(rvs), 32'(m_sv));
    chk("rdata_s", 32'(rds), 32'(m_sd));
    chk("rvalid_f", 32'(rvf), 32'(n != 0));
    chk("rdata_f", 32'(rdf), (n != 0) ? 32'(q[0]) : 32'd0);
  endtask

  always @(negedge clk) begin
    if (cmp_en) compare_all();
  end

  task automatic step(input bit w, input logic [15:0] d, input bit r,
                      input bit f = 0, input bit c = 0);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    flush   = f;
    clr_err = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    wr_en   = 0;
    rd_en   = 0;
    flush   = 0;
    clr_err = 0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Reset state
    chk("rst_count", 32'(cns), 0);
    chk("rst_empty", 32'(ems), 1);
    chk("rst_aempty", 32'(aes), 1);
    chk("rst_afull", 32'(afs), 0);
    chk("rst_rdata_s", 32'(rds), 0);
    chk("rst_rvalid_f", 32'(rvf), 0);

    // 1: fill, overflow, ordered drain (standard)
    for (int i = 0; i < 8; i++) begin
      step(1, 16'(i + 1), 0);
      chk("t1_afull", 32'(afs), 32'(i >= 5));
    end
    chk("t1_full", 32'(fus), 1);
    chk("t1_count", 32'(cns), 8);
    step(1, 16'hDEAD, 0);
    chk("t1_ovf_count", 32'(cns), 8);
    chk("t1_ovf", 32'(ovs), 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1);
      chk("t1_rvalid", 32'(rvs), 1);
      chk("t1_rdata", 32'(rds), 32'(i + 1));
    end
    step(0, 0, 0);
    chk("t1_rvalid_idle", 32'(rvs), 0);

    // 2: FWFT latency
    step(0, 0, 0, 0, 1);
    step(1, 16'h00AA, 0);
    chk("t2_rvalid_f", 32'(rvf), 1);
    chk("t2_rdata_f", 32'(rdf), 32'h00AA);
    step(0, 0, 1);
    chk("t2_empty_f", 32'(emf), 1);
    chk("t2_rdata0_f", 32'(rdf), 0);

    // 3: steady occupancy across pointer wrap
    for (int i = 0; i < 4; i++) step(1, 16'(16'h0200 + i), 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 16'(16'h0100 + i), 1);
      chk("t3_count", 32'(cns), 4);
    end
    chk("t3_rdata", 32'(rds), 32'h010F);
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    chk("t3_last", 32'(rds), 32'h0113);

    // 4: underflow with simultaneous write, clr_err races
    step(1, 16'h0055, 1);
    chk("t4_unf", 32'(uns), 1);
    chk("t4_count", 32'(cns), 1);
    chk("t4_rvalid", 32'(rvs), 0);
    step(0, 0, 0, 0, 1);
    chk("t4_clr", 32'(uns), 0);
    step(0, 0, 1);
    chk("t4_pop", 32'(rds), 32'h0055);
    step(0, 0, 1, 0, 1);
    chk("t4_unf_wins", 32'(uns), 1);
    step(0, 0, 0, 0, 1);

    // 5: flush beats wr_en/rd_en
    for (int i = 0; i < 5; i++) step(1, 16'(16'h0300 + i), 0);
    step(1, 16'h1234, 1, 1);
    chk("t5_count", 32'(cns), 0);
    chk("t5_empty", 32'(ems), 1);
    chk("t5_aempty", 32'(aes), 1);
    chk("t5_rvalid", 32'(rvs), 0);
    chk("t5_unf", 32'(uns), 0);

    // 6: asynchronous reset mid-burst
    for (int i = 0; i < 7; i++) step(1, 16'(16'h0400 + i), 0);
    wr_en   = 1;
    wr_data = 16'h0407;
    @(posedge clk);
    model_step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_count", 32'(cns), 0);
    chk("t6_empty", 32'(emf), 1);
    chk("t6_rdata_f", 32'(rdf), 0);
    chk("t6_rdata_s", 32'(rds), 0);
    chk("t6_afull", 32'(afs), 0);
    @(negedge clk);
    wr_en = 0;
    rst_n = 1'b1;
    step(1, 16'h0777, 0);
    chk("t6_first", 32'(rdf), 32'h0777);

    // Randomised traffic in fill-biased and drain-biased phases
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 400; i++) begin
        step($urandom_range(0, 99) < ((ph % 2) ? 35 : 70),
             16'($urandom),
             $urandom_range(0, 99) < ((ph % 2) ? 70 : 35),
             $urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < 4);
      end
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
